// File: rtl/tonegen_pkg.sv
// Shared definitions for the tone-generator channels.
// Holds the default period width, the phase-sequencer length and the
// duty-cycle threshold table used to shape the square wave.
package tonegen_pkg;

   // Default width of base / effective period counters (clk cycles per phase step)
   localparam int PERIOD_W_DEFAULT = 12;

   // Number of phase steps in one waveform cycle
   localparam int PHASE_STEPS = 8;

   // Duty selection codes
   typedef enum logic [1:0] {
      DUTY_12P5 = 2'd0,
      DUTY_25   = 2'd1,
      DUTY_50   = 2'd2,
      DUTY_75   = 2'd3
   } duty_e;

   // Number of phase steps (counted from phase 0) for which the tone is high
   localparam logic [2:0] DUTY_THR [4] = '{3'd1, 3'd2, 3'd4, 3'd6};

   // Threshold lookup for a duty code
   function automatic logic [2:0] duty_thr(input logic [1:0] duty);
      logic [2:0] thr;
      case (duty)
         DUTY_12P5: thr = DUTY_THR[0];
         DUTY_25:   thr = DUTY_THR[1];
         DUTY_50:   thr = DUTY_THR[2];
         DUTY_75:   thr = DUTY_THR[3];
         default:   thr = DUTY_THR[0];
      endcase
      return thr;
   endfunction

endpackage

// File: rtl/period_adder_sat.sv
// Saturating period adder: sum_o = base_i + (offset_i << VIB_SHIFT),
// evaluated one bit wider than the period and clamped to all-ones.
// Ports:
//   base_i    in   PERIOD_W  base period
//   offset_i  in   4         unsigned modulation offset
//   sum_o     out  PERIOD_W  saturated effective period
module period_adder_sat
   import tonegen_pkg::*;
#(
   parameter int PERIOD_W  = PERIOD_W_DEFAULT,
   parameter int VIB_SHIFT = 0
) (
   input  logic [PERIOD_W-1:0] base_i,
   input  logic [3:0]          offset_i,
   output logic [PERIOD_W-1:0] sum_o
);

   logic [PERIOD_W:0] off_ext_s;
   logic [PERIOD_W:0] sum_s;

   // Widen offset, scale it, add with a carry bit, clamp on overflow
   always_comb begin
      off_ext_s = {{(PERIOD_W-3){1'b0}}, offset_i} << VIB_SHIFT;
      sum_s     = {1'b0, base_i} + off_ext_s;
      if (sum_s[PERIOD_W]) begin
         sum_o = {PERIOD_W{1'b1}};
      end else begin
         sum_o = sum_s[PERIOD_W-1:0];
      end
   end

endmodule

// File: rtl/tone_oscillator.sv
// Square-wave tone channel. A programmed base period plus the vibrato
// offset gives the effective period; clk is divided by it to step an
// 8-step phase sequencer, and a duty-selectable square wave is produced.
// Ports:
//   clk           in   1         system clock
//   rst           in   1         synchronous, active-low reset
//   enable        in   1         channel enable (0 = silent, sequencer held at start)
//   period_wr     in   1         strobe: capture period_in
//   period_in     in   PERIOD_W  new base period (0 = channel off)
//   duty          in   2         0:12.5% 1:25% 2:50% 3:75%
//   vib_offset    in   4         vibrato offset from the LFO
//   tone_o        out  1         registered square wave
//   phase_o       out  3         current phase step
//   period_eff_o  out  PERIOD_W  effective period applied at the last reload
//   wrap_o        out  1         one-cycle pulse after phase 7 -> 0
module tone_oscillator
   import tonegen_pkg::*;
#(
   parameter int PERIOD_W  = PERIOD_W_DEFAULT,
   parameter int VIB_SHIFT = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                period_wr,
   input  logic [PERIOD_W-1:0] period_in,
   input  logic [1:0]          duty,
   input  logic [3:0]          vib_offset,
   output logic                tone_o,
   output logic [2:0]          phase_o,
   output logic [PERIOD_W-1:0] period_eff_o,
   output logic                wrap_o
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [2:0]          phase_q, phase_d;
   logic [PERIOD_W-1:0] base_q, base_d;
   logic [PERIOD_W-1:0] pend_q, pend_d;
   logic                pend_v_q, pend_v_d;
   logic [PERIOD_W-1:0] eff_q, eff_d;
   logic                tone_q, tone_d;
   logic                wrap_q, wrap_d;

   logic                boundary_s;
   logic [PERIOD_W-1:0] new_base_s;
   logic [PERIOD_W-1:0] eff_s;
   logic [2:0]          phase_next_s;

   // Base that takes effect at a reload: a coincident write beats the pending one
   always_comb begin
      if (period_wr) begin
         new_base_s = period_in;
      end else if (pend_v_q) begin
         new_base_s = pend_q;
      end else begin
         new_base_s = base_q;
      end
   end

   period_adder_sat #(
      .PERIOD_W  (PERIOD_W),
      .VIB_SHIFT (VIB_SHIFT)
   ) u_adder (
      .base_i   (new_base_s),
      .offset_i (vib_offset),
      .sum_o    (eff_s)
   );

   // Next-state logic for period registers, counter, sequencer and outputs
   always_comb begin
      cnt_d        = cnt_q;
      phase_d      = phase_q;
      base_d       = base_q;
      pend_d       = pend_q;
      pend_v_d     = pend_v_q;
      eff_d        = eff_q;
      tone_d       = tone_q;
      wrap_d       = 1'b0;
      phase_next_s = phase_q + 3'd1;
      boundary_s   = enable && (base_q != '0) && (cnt_q == '0);

      // Writes park in pend, except when idle where they go straight to base
      if (period_wr) begin
         if (base_q == '0) begin
            base_d = period_in;
         end else begin
            pend_d   = period_in;
            pend_v_d = 1'b1;
         end
      end else begin
         pend_v_d = pend_v_q;
      end

      if (!enable) begin
         cnt_d   = '0;
         phase_d = 3'd0;
         tone_d  = 1'b0;
      end else if (boundary_s) begin
         base_d   = new_base_s;
         pend_v_d = 1'b0;
         if (new_base_s == '0) begin
            // Channel switched off by a zero period: park the sequencer
            cnt_d   = '0;
            phase_d = 3'd0;
            tone_d  = 1'b0;
         end else begin
            cnt_d   = eff_s - PERIOD_W'(1);
            eff_d   = eff_s;
            phase_d = phase_next_s;
            tone_d  = (phase_next_s < duty_thr(duty));
            wrap_d  = (phase_q == 3'd7);
         end
      end else if (base_q == '0) begin
         cnt_d   = '0;
         phase_d = 3'd0;
         tone_d  = 1'b0;
      end else begin
         cnt_d = cnt_q - PERIOD_W'(1);
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q    <= '0;
         phase_q  <= 3'd0;
         base_q   <= '0;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         eff_q    <= '0;
         tone_q   <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         base_q   <= base_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         eff_q    <= eff_d;
         tone_q   <= tone_d;
         wrap_q   <= wrap_d;
      end
   end

   assign tone_o       = tone_q;
   assign phase_o      = phase_q;
   assign period_eff_o = eff_q;
   assign wrap_o       = wrap_q;

endmodule

// File: tb/tb_tone_oscillator.sv
// Self-checking bench for tone_oscillator: directed scenarios followed by
// randomized traffic, all compared every cycle against a time-based model.
module tb_tone_oscillator;

   localparam int W    = 12;
   localparam int MAXP = (1 << W) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          enable = 1'b0;
   logic          period_wr = 1'b0;
   logic [W-1:0]  period_in = '0;
   logic [1:0]    duty = 2'd0;
   logic [3:0]    vib_offset = 4'd0;
   logic          tone_o;
   logic [2:0]    phase_o;
   logic [W-1:0]  period_eff_o;
   logic          wrap_o;

   tone_oscillator #(.PERIOD_W(W), .VIB_SHIFT(0)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .period_wr    (period_wr),
      .period_in    (period_in),
      .duty         (duty),
      .vib_offset   (vib_offset),
      .tone_o       (tone_o),
      .phase_o      (phase_o),
      .period_eff_o (period_eff_o),
      .wrap_o       (wrap_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: time since the current step started, and its length
   int m_base, m_len, m_t, m_phase, m_tone, m_wrap, m_eff;
   int m_pend[$];
   int high_steps [4] = '{1, 2, 4, 6};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   function automatic int sat_eff(input int b, input int v);
      int s;
      s = b + v;
      return (s > MAXP) ? MAXP : s;
   endfunction

   // Advance the model by one clock edge using the inputs currently applied
   task automatic model_edge();
      int nb;
      bit boundary;
      if (!rst) begin
         m_base = 0; m_len = 0; m_t = 0; m_phase = 0;
         m_tone = 0; m_wrap = 0; m_eff = 0;
         m_pend.delete();
         return;
      end
      m_wrap = 0;
      boundary = enable && (m_base != 0) && (m_len == 0 || m_t + 1 == m_len);
      if (boundary) begin
         if (period_wr) nb = int'(period_in);
         else if (m_pend.size() > 0) nb = m_pend[$];
         else nb = m_base;
         m_pend.delete();
         m_base = nb;
         if (nb == 0) begin
            m_len = 0; m_phase = 0; m_tone = 0;
         end else begin
            m_eff   = sat_eff(nb, int'(vib_offset));
            m_len   = m_eff;
            m_t     = 0;
            m_wrap  = (m_phase == 7);
            m_phase = (m_phase + 1) % 8;
            m_tone  = (m_phase < high_steps[duty]);
         end
      end else begin
         if (period_wr) begin
            if (m_base == 0) m_base = int'(period_in);
            else m_pend.push_back(int'(period_in));
         end
         if (!enable || m_base == 0 || m_len == 0) begin
            m_len = 0; m_phase = 0; m_tone = 0;
         end else begin
            m_t++;
         end
         // Bypass write while enabled and idle: still zero length, reload next edge
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      chk("tone",  {31'd0, tone_o},        m_tone);
      chk("phase", {29'd0, phase_o},       m_phase);
      chk("eff",   {20'd0, period_eff_o},  m_eff);
      chk("wrap",  {31'd0, wrap_o},        m_wrap);
   endtask

   task automatic write_period(input int p);
      period_wr = 1'b1;
      period_in = W'(p);
      tick();
      period_wr = 1'b0;
   endtask

   // Ticks until phase_o leaves its current value; returns elapsed cycles
   task automatic step_len(output int n);
      logic [2:0] ph;
      ph = phase_o;
      n = 0;
      while (phase_o == ph && n < 5000) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int last_wrap, prev_wrap, highs, n;

      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         enable = 1'($urandom); period_wr = 1'($urandom);
         period_in = W'($urandom); duty = 2'($urandom); vib_offset = 4'($urandom);
         tick();
         chk("reset_tone", {31'd0, tone_o}, 32'd0);
         chk("reset_eff",  {20'd0, period_eff_o}, 32'd0);
      end

      // Idle after release: no base, no tone
      rst = 1'b1; period_wr = 1'b0; enable = 1'b1;
      highs = 0;
      for (int i = 0; i < 100; i++) begin
         duty = 2'($urandom); vib_offset = 4'($urandom);
         tick();
         highs += int'(tone_o);
      end
      chk("idle_silent", highs, 0);

      // Basic tone: period 10, 50% duty
      duty = 2'd2; vib_offset = 4'd0;
      write_period(10);
      last_wrap = 0; prev_wrap = 0; highs = 0;
      for (int i = 0; i < 250; i++) begin
         tick();
         if (wrap_o) begin prev_wrap = last_wrap; last_wrap = cyc; end
         if (i < 80) highs += int'(tone_o);
      end
      chk("wrap_interval", last_wrap - prev_wrap, 80);
      chk("high_cycles_50", highs, 40);
      chk("basic_eff", {20'd0, period_eff_o}, 32'd10);

      // Vibrato change mid-step
      for (int i = 0; i < 4; i++) tick();
      vib_offset = 4'd5;
      for (int i = 0; i < 60; i++) tick();
      chk("vib_eff", {20'd0, period_eff_o}, 32'd15);

      // Saturation
      vib_offset = 4'd15;
      write_period(4090);
      enable = 1'b0; tick();
      enable = 1'b1; tick();
      chk("sat_eff", {20'd0, period_eff_o}, MAXP);

      // Glitch-free writes: base 20, then 7 and 9 written mid-step
      vib_offset = 4'd0;
      write_period(20);
      enable = 1'b0; tick();
      enable = 1'b1; tick();
      for (int i = 0; i < 7; i++) tick();
      write_period(7);
      for (int i = 0; i < 6; i++) tick();
      write_period(9);
      step_len(n);
      chk("step_20", n + 15, 20);
      step_len(n);
      chk("step_9", n, 9);
      // Write landing exactly on the reload cycle
      for (int i = 0; i < 8; i++) tick();
      write_period(13);
      chk("write_at_zero", {20'd0, period_eff_o}, 32'd13);

      // Duty 0 and enable drop / restore
      duty = 2'd0;
      highs = 0;
      for (int i = 0; i < 104; i++) begin tick(); highs += int'(tone_o); end
      chk("high_cycles_12", highs, 13);
      for (int i = 0; i < 5; i++) tick();
      enable = 1'b0; tick();
      chk("dis_phase", {29'd0, phase_o}, 32'd0);
      chk("dis_tone",  {31'd0, tone_o},  32'd0);
      enable = 1'b1; tick();
      chk("reen_phase", {29'd0, phase_o}, 32'd1);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst        = ($urandom_range(0, 199) != 0);
         enable     = ($urandom_range(0, 19) != 0);
         period_wr  = ($urandom_range(0, 9) == 0);
         period_in  = ($urandom_range(0, 15) == 0) ? W'(0) : W'($urandom_range(1, 24));
         duty       = 2'($urandom);
         vib_offset = 4'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
